// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction out,
// one response back. All AXI outputs are registered; valids never depend on readies.
module axilite_master #(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [1:0]  RESP_OKAY   = 2'b00,
  parameter logic [1:0]  RESP_SLVERR = 2'b10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_SIZE-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI-Lite write channels
  output logic [ADDR_SIZE-1:0]      awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI-Lite read channels
  output logic [ADDR_SIZE-1:0]      araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  // Elaboration-time sanity check on the parameter set.
  if ((DATA_WIDTH % 8) != 0 || RESP_SLVERR == RESP_OKAY) begin : g_param_check
    $error("axilite_master: DATA_WIDTH must be a multiple of 8 and response codes distinct");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata,
    StResp
  } state_e;

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      bready_q, bready_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  // AW and W are done once their valid has dropped or handshakes this cycle.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRead;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = StWresp;
          bready_d = 1'b1;
        end
      end
      StWresp: begin
        if (bvalid) begin
          state_d     = StResp;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
        end
      end
      StRead: begin
        if (arready) begin
          state_d   = StRdata;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StRdata: begin
        if (rvalid) begin
          state_d     = StResp;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: a table of transactions with per-channel slave delays
// and hand-computed handshake counts/latencies, plus a reset-mid-transaction sequence.
module tb_axilite_master;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_fail = 0;

  axilite_master #(
    .ADDR_SIZE (32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_aw, exp_w, exp_b, exp_ar, exp_r, exp_rsp_cyc;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];
  vec_t post_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_slave();
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b11;
    arready = 0; rvalid = 0; rresp = 2'b11; rdata = 32'hBAD0BAD0;
    rsp_ready = 0;
  endtask

  // Issue one command, play the slave with the given delays, and check the outcome.
  // Called #1 after a rising edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    int aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0, rsp_hi = 0;
    int rsp_cyc = 0, viol = 0;
    bit done = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_resp = '0;
    logic        s_write = 0;
    string p = $sformatf("v%0d", idx);
    chk({p, "_cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(posedge aclk); #1;
    // Scramble the command bus to prove the DUT latched it.
    cmd_valid = 0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
    cmd_wstrb = ~v.wstrb;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      if (cmd_ready) viol++;
      if (awvalid && awaddr !== v.addr) viol++;
      if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) viol++;
      if (arvalid && araddr !== v.addr) viol++;
      if (bready && (awvalid || wvalid)) viol++;
      if (rready && arvalid) viol++;
      awready = awvalid && (aw_hi >= v.aw_dly);
      if (awvalid) aw_hi++;
      wready = wvalid && (w_hi >= v.w_dly);
      if (wvalid) w_hi++;
      bvalid = bready && (b_hi >= v.b_dly);
      bresp  = bvalid ? v.resp : 2'b11;
      if (bready) b_hi++;
      arready = arvalid && (ar_hi >= v.ar_dly);
      if (arvalid) ar_hi++;
      rvalid = rready && (r_hi >= v.r_dly);
      rdata  = rvalid ? v.rdata : 32'hBAD0BAD0;
      rresp  = rvalid ? v.resp : 2'b11;
      if (rready) r_hi++;
      if (rsp_valid) begin
        if (rsp_hi == 0) begin
          rsp_cyc = cyc; s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
        end else if (rsp_rdata !== s_rdata || rsp_resp !== s_resp || rsp_write !== s_write) begin
          viol++;
        end
        rsp_ready = (rsp_hi >= v.rsp_dly);
        done = rsp_ready;
        rsp_hi++;
      end else begin
        rsp_ready = 0;
      end
      @(posedge aclk); #1;
    end
    idle_slave();
    chk({p, "_completed"}, done, 1);
    chk({p, "_aw_cycles"}, aw_hi, v.exp_aw);
    chk({p, "_w_cycles"}, w_hi, v.exp_w);
    chk({p, "_bready_cycles"}, b_hi, v.exp_b);
    chk({p, "_ar_cycles"}, ar_hi, v.exp_ar);
    chk({p, "_rready_cycles"}, r_hi, v.exp_r);
    chk({p, "_rsp_cycle"}, rsp_cyc, v.exp_rsp_cyc);
    chk({p, "_rsp_write"}, s_write, v.write);
    chk({p, "_rsp_resp"}, s_resp, v.exp_resp);
    chk({p, "_rsp_rdata"}, s_rdata, v.exp_rdata);
    chk({p, "_protocol_violations"}, viol, 0);
    chk({p, "_rsp_valid_dropped"}, rsp_valid, 0);
    chk({p, "_cmd_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    //        wr    addr          wdata         strb  aw w b ar r rsp resp rdata
    //        exp:  aw w b ar r rspcyc resp rdata
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,
                1, 1, 1, 0, 0, 3, 2'd0, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h1111_2222, 4'hF, 3, 0, 0, 0, 0, 0, 2'd0, 32'h0,
                4, 1, 1, 0, 0, 6, 2'd0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'h3333_4444, 4'hC, 0, 3, 0, 0, 0, 0, 2'd0, 32'h0,
                1, 4, 1, 0, 0, 6, 2'd0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 5, 0, 2'd0, 32'h1234_5678,
                0, 0, 0, 1, 6, 8, 2'd0, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 0, 0, 2, 0, 0, 0, 2'd2, 32'h0,
                1, 1, 3, 0, 0, 5, 2'd2, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 32'hCAFE_F00D,
                0, 0, 0, 1, 1, 3, 2'd0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 0, 0, 10, 2'd0, 32'h0,
                1, 1, 1, 0, 0, 3, 2'd0, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_1001, 32'h0, 4'h0, 0, 0, 0, 2, 0, 0, 2'd2, 32'h55AA_55AA,
                0, 0, 0, 3, 1, 5, 2'd2, 32'h55AA_55AA};
    vecs[8] = '{1'b1, 32'h0000_002C, 32'h0102_0304, 4'h1, 2, 2, 0, 0, 0, 0, 2'd0, 32'h0,
                3, 3, 1, 0, 0, 5, 2'd0, 32'h0};
    post_rst = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0F0F_0F0F,
                 0, 0, 0, 1, 1, 3, 2'd0, 32'h0F0F_0F0F};

    aresetn = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    idle_slave();
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
    chk("rst_readies", {bready, rready}, 2'b00);
    chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, '0);
    chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, '0);
    aresetn = 1;
    @(posedge aclk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-write while awvalid/wvalid are up.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h7777_8888; cmd_wstrb = 4'hF;
    @(posedge aclk); #1;
    cmd_valid = 0;
    chk("midrst_pre_awvalid", awvalid, 1);
    chk("midrst_pre_wvalid", wvalid, 1);
    #2 aresetn = 0;
    #1;
    chk("midrst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
    chk("midrst_readies", {bready, rready}, 2'b00);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_regs", {awaddr, wdata, wstrb}, '0);
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;
    chk("midrst_cmd_ready_release", cmd_ready, 1);
    run_vec(9, post_rst);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- Single-outstanding AXI4-Lite master. It turns simple command requests from on-chip logic into AXI-Lite read and write transactions.
- Typical users are the config sequencers and test harnesses that drive the register cells of the coprocessor.
- Each command returns exactly one response carrying read data and the bus response code.
- It is the initiator end of the AXI-Lite slave register interface already used in the design.

Parameters:
- ADDR_SIZE, 32, width of command address and awaddr/araddr.
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- RESP_OKAY, 0, OKAY response encoding.
- RESP_SLVERR, 2, SLVERR response encoding (reference value only; the block does not generate it).

Ports:
- aclk  in  1  clock; everything is sampled on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp, unmodified.
- awaddr  out  ADDR_SIZE  write address.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  DATA_WIDTH  write data.
- wstrb  out  DATA_WIDTH/8  write strobes.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  2  write response code.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.
- araddr  out  ADDR_SIZE  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  2  read response code.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready and rsp_valid are all 0.
  - Address, data, strobe and response registers are 0.
  - Reset has immediate effect mid-transaction; any in-flight AXI transfer is abandoned. The system resets master and slave together.
- State machine states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- cmd_ready = 1 only in IDLE (decoded from state). A command is accepted on an edge where cmd_valid && cmd_ready.
- IDLE, command accepted:
  - Latch addr, wdata, wstrb and write flag.
  - Write: go to WRITE; awvalid = 1 and wvalid = 1 from the next cycle.
  - Read: go to READ; arvalid = 1 from the next cycle.
- WRITE:
  - awvalid drops on the edge after awvalid && awready; wvalid drops on the edge after wvalid && wready. The two handshakes are tracked independently and may complete in either order or in the same cycle.
  - When both are done (including the cycle the last one completes), go to WRESP with bready = 1.
- WRESP: on bvalid && bready, capture bresp into rsp_resp, set rsp_rdata = 0, rsp_write = 1. bready goes to 0 and rsp_valid to 1 next cycle; go to RESP.
- READ: on arvalid && arready, arvalid goes to 0 and rready to 1; go to RDATA.
- RDATA: on rvalid && rready, capture rdata and rresp, set rsp_write = 0. rready goes to 0 and rsp_valid to 1; go to RESP.
- RESP:
  - rsp_valid and the rsp_* fields hold steady until rsp_valid && rsp_ready.
  - Then rsp_valid goes to 0 and the state returns to IDLE.
  - cmd_ready rises the cycle after the response handshake; there is no bypass.
- AXI rules:
  - A valid, once raised, stays high with stable payload until its handshake.
  - Valids never depend combinationally on readies.
  - awaddr, wdata, wstrb and araddr are registered and hold the latched command for the whole transaction.
- Latency with a zero-wait slave:
  - Write: cmd accept at edge 0, AW/W handshake at edge 1, B at edge 2, rsp_valid high in cycle 3.
  - Read: cmd accept at edge 0, AR at edge 1, R at edge 2, rsp_valid high in cycle 3.
- Only one transaction is outstanding at a time.
- The block passes error responses through unchanged and does not retry.
- Addresses are passed as-is; the block does not check alignment.
- Inputs bvalid and rvalid are ignored outside WRESP and RDATA respectively.

Test Plan:
- Zero-wait slave, write addr 0x8, data 0xDEADBEEF, wstrb 0xF -> awvalid and wvalid high for 1 cycle, bready for 1 cycle, rsp_valid in cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid stays high 4 cycles with awaddr stable; then the reverse order (wready delayed) -> bready only after both handshakes.
- Read addr 0x4, arready immediate, rvalid delayed 5 cycles with rdata 0x12345678 -> rready held 6 cycles, rsp_rdata=0x12345678, rsp_resp=0.
- Slave returns bresp=2 on a write -> rsp_resp=2; next command accepted normally.
- rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready rises.
- aresetn pulsed low while awvalid is high -> all valids and readies 0 immediately, state IDLE, cmd_ready=1 after release; a following read completes correctly.
